// File: rtl/seg7_pkg.sv
// Purpose: shared segment ordering and glyph tables for the 7-segment scan driver.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package seg7_pkg;

  // Segment order inside every 7-bit segment vector: bit 6 = G ... bit 0 = A.
  typedef struct packed {
    logic g;
    logic f;
    logic e;
    logic d;
    logic c;
    logic b;
    logic a;
  } seg_t;

  // Glyph set selector.
  typedef enum logic {
    MODE_HEX  = 1'b0,
    MODE_GAME = 1'b1
  } glyph_mode_e;

  // Active-low "all segments off".
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Hex glyphs 0-9, A b C d E F (active low, GFEDCBA).
  localparam logic [6:0] GLYPH_HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Game glyphs: digits as hex, then t r y L E and a blank in place of F.
  localparam logic [6:0] GLYPH_GAME [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0000111, 7'b0101111,
    7'b0010001, 7'b1000111, 7'b0000110, 7'b1111111
  };

endpackage

// File: rtl/seg7_glyph_rom.sv
// Purpose: maps a 4-bit digit code to an active-low GFEDCBA segment pattern.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs continuously.
module seg7_glyph_rom
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  input  logic       mode,
  output logic [6:0] seg
);

  // Table select by glyph mode, then index by code.
  always_comb begin
    seg = SEG_BLANK;
    if (mode == MODE_GAME) begin
      seg = GLYPH_GAME[code];
    end else begin
      seg = GLYPH_HEX[code];
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Purpose: time-multiplexed 7-segment scanner with guard blanking, blink and frame-synchronous reload.
// Latency: seg/dp_n/an registered, one cycle behind prescaler/index; loads take effect at the next frame wrap.
// Backpressure: none; load is a fire-and-forget strobe and a later load simply overwrites the pending copy.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD        = 2,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    mode,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   blank;
    logic [NUM_DIGITS-1:0]   blink;
    logic                    mode;
  } cfg_t;

  // Everything blanked so the display stays dark until the first commit.
  localparam cfg_t CFG_RST = '{digits: '0, dp: '0, blank: '1, blink: '0, mode: 1'b0};

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [BW-1:0]         blink_cnt_q, blink_cnt_d;
  logic                  phase_q, phase_d;
  cfg_t                  pend_q, pend_d;
  cfg_t                  act_q, act_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_n_q, dp_n_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic       presc_wrap;
  logic       frame_wrap;
  cfg_t       in_cfg;
  logic [3:0] code;
  logic [6:0] glyph;
  logic       dark;

  // Scan counters, blink phase and the pending/active configuration pair.
  always_comb begin
    in_cfg      = '{digits: digits, dp: dp, blank: blank_mask, blink: blink_mask, mode: mode};
    presc_wrap  = (presc_q == PW'(REFRESH_DIV - 1));
    frame_wrap  = presc_wrap && (idx_q == IW'(NUM_DIGITS - 1));
    presc_d     = presc_wrap ? '0 : presc_q + PW'(1);
    idx_d       = idx_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (presc_wrap) begin
      idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
    if (frame_wrap) begin
      if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
    // A load coinciding with the wrap bypasses pending and lands in active directly.
    pend_d = load ? in_cfg : pend_q;
    act_d  = frame_wrap ? pend_d : act_q;
  end

  assign code = act_q.digits[{idx_q, 2'b00} +: 4];

  seg7_glyph_rom u_rom (
    .code (code),
    .mode (act_q.mode),
    .seg  (glyph)
  );

  // Next registered drive: dark during guard, blank mask or blink-off phase.
  always_comb begin
    dark = (presc_q < PW'(GUARD)) || act_q.blank[idx_q] || (act_q.blink[idx_q] && phase_q);
    seg_d  = SEG_BLANK;
    dp_n_d = 1'b1;
    an_d   = '1;
    if (!dark) begin
      seg_d       = glyph;
      dp_n_d      = ~act_q.dp[idx_q];
      an_d[idx_q] = 1'b0;
    end
  end

  // State registers; reset drops any pending load and darkens outputs at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q     <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      pend_q      <= CFG_RST;
      act_q       <= CFG_RST;
      seg_q       <= SEG_BLANK;
      dp_n_q      <= 1'b1;
      an_q        <= '1;
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      pend_q      <= pend_d;
      act_q       <= act_d;
      seg_q       <= seg_d;
      dp_n_q      <= dp_n_d;
      an_q        <= an_d;
    end
  end

  assign seg        = seg_q;
  assign dp_n       = dp_n_q;
  assign an         = an_q;
  // High during the cycle whose closing edge wraps the digit index to 0.
  assign frame_tick = frame_wrap;

endmodule
